// File: rtl/i2c_pkg.sv
// Shared I2C controller types: receiver state encoding, ACK/NAK line levels,
// and a majority-vote helper for the optional SDA glitch filter.
package i2c_pkg;

  typedef enum logic [1:0] {
    kIdle    = 2'd0,
    kReceive = 2'd1,
    kAck     = 2'd2
  } rx_state_t;

  localparam logic kI2cAck = 1'b0;
  localparam logic kI2cNak = 1'b1;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_if.sv
// Shared I2C bus: sda_i is the resolved line level, sda_oe=1 pulls SDA low
// (open drain, never driven high); the pad or board pull-up resolves the wire.
interface i2c_if;
  logic scl;
  logic sda_i;
  logic sda_oe;

  modport ctrl_rx (input scl, input sda_i, output sda_oe);
  modport periph  (input scl, input sda_oe, output sda_i);
endinterface

// File: rtl/i2c_edge_det.sv
// SCL edge detector and SDA sampler; RX_GLITCH_FILTER_EN adds a 2-sample SCL
// agreement filter and 3-stage SDA majority vote (+2 clocks of edge latency).
module i2c_edge_det
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic scl_i,
  input  logic sda_i,
  output logic rise_o,
  output logic fall_o,
  output logic sda_o
);

`ifdef RX_GLITCH_FILTER_EN
  logic [1:0] scl_sync_q;
  logic       scl_f_q;
  logic       scl_f_d;
  logic [2:0] sda_sr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_sync_q <= 2'b11;
      scl_f_q    <= 1'b1;
      sda_sr_q   <= 3'b111;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      scl_f_q    <= scl_f_d;
      sda_sr_q   <= {sda_sr_q[1:0], sda_i};
    end
  end

  // Filtered level only moves once two consecutive samples agree.
  always_comb begin
    scl_f_d = (scl_sync_q[0] == scl_sync_q[1]) ? scl_sync_q[0] : scl_f_q;
    rise_o  = scl_f_d & ~scl_f_q;
    fall_o  = ~scl_f_d & scl_f_q;
    sda_o   = maj3(sda_sr_q);
  end
`else
  logic scl_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_q <= 1'b1;
    end else begin
      scl_q <= scl_i;
    end
  end

  always_comb begin
    rise_o = scl_i & ~scl_q;
    fall_o = ~scl_i & scl_q;
    sda_o  = sda_i;
  end
`endif

endmodule

// File: rtl/i2c_rx.sv
// Controller-side I2C byte receiver: MSB-first byte assembly, ACK/NAK on the 9th clock,
// SCL stall timeout. Optional RX_GLITCH_FILTER_EN input filtering lives in i2c_edge_det.
module i2c_rx
  import i2c_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int CLK_DIV     = CLK_FREQ / 100_000,
  parameter int TIMEOUT_CYC = 4 * CLK_DIV,
  parameter int TO_LEN      = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic         clk,
  input  logic         rstn,
  i2c_if.ctrl_rx       i2c,
  input  logic         rx,
  input  logic         nack_last,
  output logic [7:0]   data,
  output logic         data_valid,
  output logic         busy,
  output logic         err
);

  localparam logic [TO_LEN-1:0] kToMax = TO_LEN'(TIMEOUT_CYC - 1);

  rx_state_t         state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [7:0]        data_q, data_d;
  logic              dvld_q, dvld_d;
  logic              ack_drive_q, ack_drive_d;
  logic              err_q, err_d;
  logic [TO_LEN-1:0] to_cnt_q, to_cnt_d;

  logic scl_rise;
  logic scl_fall;
  logic sda_smp;
  logic resp;

  i2c_edge_det u_edge (
    .clk    (clk),
    .rstn   (rstn),
    .scl_i  (i2c.scl),
    .sda_i  (i2c.sda_i),
    .rise_o (scl_rise),
    .fall_o (scl_fall),
    .sda_o  (sda_smp)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= kIdle;
      cnt_q       <= 3'd7;
      shreg_q     <= 8'h00;
      data_q      <= 8'h00;
      dvld_q      <= 1'b0;
      ack_drive_q <= 1'b0;
      err_q       <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      dvld_q      <= dvld_d;
      ack_drive_q <= ack_drive_d;
      err_q       <= err_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    dvld_d      = 1'b0;
    ack_drive_d = ack_drive_q;
    err_d       = err_q;
    to_cnt_d    = '0;
    resp        = nack_last ? kI2cNak : kI2cAck;

    if (state_q != kIdle) begin
      to_cnt_d = (scl_rise || scl_fall) ? '0 : to_cnt_q + TO_LEN'(1);
    end

    case (state_q)
      kIdle: begin
        if (!rx && !i2c.scl) begin
          state_d = kReceive;
          cnt_d   = 3'd7;
          shreg_d = 8'h00;
          err_d   = 1'b0;
        end
      end
      kReceive: begin
        if (scl_rise) begin
          shreg_d[cnt_q] = sda_smp;
        end
        if (scl_fall) begin
          if (cnt_q == 3'd0) begin
            state_d     = kAck;
            data_d      = shreg_q;
            dvld_d      = 1'b1;
            ack_drive_d = (resp == kI2cAck);
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      kAck: begin
        if (scl_fall) begin
          if (ack_drive_q && !rx) begin
            state_d = kReceive;
            cnt_d   = 3'd7;
            shreg_d = 8'h00;
          end else begin
            state_d = kIdle;
          end
        end
      end
      default: state_d = kIdle;
    endcase

    // A stalled bus abandons the byte without publishing it.
    if (state_q != kIdle && to_cnt_q == kToMax) begin
      state_d  = kIdle;
      err_d    = 1'b1;
      dvld_d   = 1'b0;
      data_d   = data_q;
      to_cnt_d = '0;
    end
  end

  assign i2c.sda_oe = (state_q == kAck) && ack_drive_q;
  assign data       = data_q;
  assign data_valid = dvld_q;
  assign busy       = (state_q != kIdle);
  assign err        = err_q;

endmodule

// File: doc/i2c_rx.md
Name: i2c_rx

Overview:
Controller-side I2C byte receiver, the read-direction counterpart of the byte transmitter. SCL is generated elsewhere. This block samples SDA on each SCL high phase and assembles MSB-first bytes. On the 9th clock it drives ACK, or NAK for the last byte of a read. It sits beside the transmitter on the shared i2c_if, under the controller sequencer that issues START/STOP.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
CLK_DIV, CLK_FREQ / 100_000, system clocks per SCL period
TIMEOUT_CYC, 4 * CLK_DIV, max clocks SCL may stay in one level while busy before abort
TO_LEN, $clog2(TIMEOUT_CYC + 1), timeout counter width

Ports:
clk  input  1  system clock, all logic on posedge
rstn  input  1  asynchronous active-low reset
i2c  interface  i2c_if.ctrl_rx  sda (inout, open-drain, block drives only 0 or Z), scl (input)
rx  input  1  receive request, active low
nack_last  input  1  1 = answer the current byte with NAK; sampled at the ACK-slot entry
data  output  8  last received byte, held until the next byte completes
data_valid  output  1  one-clock pulse, byte in data is new
busy  output  1  high in any state other than kIdle
err  output  1  sticky timeout flag, cleared when a new reception starts

Behaviour:
- Reset is asynchronous, active low. State returns to kIdle and SDA is released the same instant, since SDA is decoded combinationally from state. data=8'h00, data_valid=0, busy=0, err=0, bit counter=7.
- SCL is registered once (scl_q). rise = scl & !scl_q; fall = !scl & scl_q. Both are single-cycle pulses.
- States: kIdle, kReceive, kAck.
- kIdle: SDA released. Move to kReceive at the posedge where rx==0 and scl==0. On that move: counter=7, shift register=0, err=0.
- kReceive: SDA released. On rise, shift_reg[counter] <= sda. On fall with counter==0, go to kAck; otherwise decrement counter on fall. A rise when counter==0 captures bit 0.
- Entering kAck, on the same clock:
  - data <= shift_reg (with bit 0 included) and data_valid pulses for one clock.
  - ack_drive is latched as !nack_last.
- kAck: SDA is driven 0 while ack_drive==1, released otherwise, for the whole 9th SCL low+high phase. The ACK bit is set up during SCL low. On the next fall:
  - release SDA;
  - if ack_drive==1 and rx==0, go to kReceive with counter=7;
  - otherwise go to kIdle.
- After a NAK the block always returns to kIdle, whatever rx is.
- rx deasserted mid-byte is ignored: the byte completes and is ACKed or NAKed per nack_last.
- SDA transitions while SCL is high (START/STOP) are not detected. Only the value present at rise is used.
- Timeout: while busy, a counter runs and clears on every SCL edge. When it reaches TIMEOUT_CYC-1: err<=1, go to kIdle, release SDA, no data_valid.
- Latency: data_valid asserts 1 clock after the 8th SCL falling edge is seen in scl_q. SDA ACK drive starts that same clock.

Optional Feature:
RX_GLITCH_FILTER_EN. When defined:
- SDA passes through a 3-stage shift register.
- The sampled bit is the majority of the 3 stages.
- SCL passes through a 2-sample agreement filter before edge detection.
- Latency grows by 2 clocks.
When undefined: raw SDA is sampled at rise and edges come from the single scl_q register, as above.

Decomposition:
- Shared i2c_pkg holds typedef rx_state_t (kIdle=0, kReceive=1, kAck=2) and constants kI2cAck=1'b0, kI2cNak=1'b1.
- One sub-module, i2c_edge_det: SCL register/filter, outputs rise and fall pulses. It hosts the RX_GLITCH_FILTER_EN logic and can be reused by the transmitter.

Test Plan:
- Peripheral model sends 8'hA5 with nack_last=0 → data=8'hA5, one data_valid pulse, SDA==0 throughout the 9th SCL high phase, then SDA released.
- Two bytes 8'h3C then 8'hC3, rx held low, nack_last=1 on the second → first ACKed, second NAKed (SDA Z on the 9th clock), two data_valid pulses, busy low after the final fall.
- Byte 8'hFF, then 8'h00 → data matches each value; check SDA is never driven 0 during data bits.
- SCL stuck high for TIMEOUT_CYC clocks mid-byte → err=1, state kIdle, SDA Z, no data_valid. Next rx low clears err.
- rstn pulled low after bit 4 of 8'h5A → SDA released asynchronously, data=8'h00, busy=0. The next full byte 8'h81 is received correctly.
- With RX_GLITCH_FILTER_EN, a 1-clock SDA glitch during SCL high on bit 3 of 8'h66 → data=8'h66.
